// File: rtl/i2s_rx_interface_if.sv
// I2S receive bus: codec-side serial inputs plus the parallel sample outputs.
// master drives the serial lines (codec/model side); slave is the receiver.
interface i2s_rx_interface_if #(
    parameter int DATA_W = 24
);
    logic              i2s_bclk;
    logic              i2s_lr;
    logic              i2s_d_in;
    logic [DATA_W-1:0] audio_l_out;
    logic [DATA_W-1:0] audio_r_out;
    logic              sample_valid;
    logic              frame_err;
    logic              locked;

    modport master (
        output i2s_bclk, i2s_lr, i2s_d_in,
        input  audio_l_out, audio_r_out, sample_valid, frame_err, locked
    );

    modport slave (
        input  i2s_bclk, i2s_lr, i2s_d_in,
        output audio_l_out, audio_r_out, sample_valid, frame_err, locked
    );
endinterface

// File: rtl/i2s_rx_interface.sv
// I2S capture: oversamples codec BCLK/LRCLK/SDATA on clk and emits one
// left/right sample pair per LRCLK frame with a single-cycle valid strobe.
module i2s_rx_interface #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    i2s_rx_interface_if.slave    bus
);
    localparam int SLOT_W = $clog2(DATA_W + 2);
    localparam logic [SLOT_W-1:0] SLOT_DW  = SLOT_W'(DATA_W);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(DATA_W + 1);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        LEFT,
        RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] d_sync_q;
    logic                   bclk_prev_q;

    state_t                 state_q,     state_d;
    logic [SLOT_W-1:0]      slot_q,      slot_d;
    logic                   lr_prev_q,   lr_prev_d;
    logic [DATA_W-1:0]      shreg_q,     shreg_d;
    logic [DATA_W-1:0]      l_hold_q,    l_hold_d;
    logic                   got_left_q,  got_left_d;
    logic                   word_done_q, word_done_d;
    logic [DATA_W-1:0]      audio_l_q,   audio_l_d;
    logic [DATA_W-1:0]      audio_r_q,   audio_r_d;
    logic                   valid_q,     valid_d;
    logic                   err_q,       err_d;
    logic                   locked_q,    locked_d;

    logic                   bclk_s, lr_s, d_s, bclk_rise;
    logic [SLOT_W-1:0]      slot_inc;

    // lr and data come from the same stage as bclk so all three stay aligned.
    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s      = lr_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        lr_prev_d   = lr_prev_q;
        shreg_d     = shreg_q;
        l_hold_d    = l_hold_q;
        got_left_d  = got_left_q;
        word_done_d = 1'b0;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked_q;
        slot_inc    = (slot_q == SLOT_MAX) ? slot_q : slot_q + 1'b1;

        if (bclk_rise) begin
            if (lr_s != lr_prev_q) begin
                slot_d    = '0;
                lr_prev_d = lr_s;
                case (state_q)
                    SYNC_WAIT: begin
                        if (!lr_s) begin
                            state_d  = LEFT;
                            locked_d = 1'b1;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (slot_q < SLOT_DW) begin
                            err_d      = 1'b1;
                            got_left_d = 1'b0;
                        end
                        state_d = lr_s ? RIGHT : LEFT;
                    end
                    default: state_d = SYNC_WAIT;
                endcase
            end else begin
                slot_d = slot_inc;
                if (slot_inc != '0 && slot_inc <= SLOT_DW) begin
                    shreg_d = {shreg_q[DATA_W-2:0], d_s};
                end
                word_done_d = (slot_inc == SLOT_DW) && (slot_q != SLOT_DW);
            end
        end

        // Word completes one cycle after its last bit lands in shreg.
        if (word_done_q) begin
            case (state_q)
                LEFT: begin
                    l_hold_d   = shreg_q;
                    got_left_d = 1'b1;
                end
                RIGHT: begin
                    // Only publish whole frames so L and R never mix.
                    if (got_left_q) begin
                        audio_r_d = shreg_q;
                        audio_l_d = l_hold_q;
                        valid_d   = 1'b1;
                    end
                    got_left_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            d_sync_q    <= '0;
            bclk_prev_q <= 1'b0;
            state_q     <= SYNC_WAIT;
            slot_q      <= '0;
            lr_prev_q   <= 1'b0;
            shreg_q     <= '0;
            l_hold_q    <= '0;
            got_left_q  <= 1'b0;
            word_done_q <= 1'b0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bus.i2s_bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], bus.i2s_lr};
            d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], bus.i2s_d_in};
            bclk_prev_q <= bclk_s;
            state_q     <= state_d;
            slot_q      <= slot_d;
            lr_prev_q   <= lr_prev_d;
            shreg_q     <= shreg_d;
            l_hold_q    <= l_hold_d;
            got_left_q  <= got_left_d;
            word_done_q <= word_done_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.audio_l_out  = audio_l_q;
    assign bus.audio_r_out  = audio_r_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.locked       = locked_q;
endmodule

// File: tb/tb_i2s_rx_interface.sv
// Directed bench for i2s_rx_interface: drives I2S frames from a codec model
// and compares captured pairs, strobes and errors against hand-set values.
`timescale 1ps/1ps
module tb_i2s_rx_interface;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   bh  = 162760;          // BCLK half period, 3.072 MHz
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   vcount = 0, ecount = 0, vwide = 0, ewide = 0;
    int   vtimes[$];
    logic [23:0] lq[$];
    logic [23:0] rq[$];
    logic prev_v = 1'b0, prev_e = 1'b0;

    i2s_rx_interface_if #(.DATA_W(24)) bus();

    i2s_rx_interface #(.DATA_W(24), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10417 clk = ~clk;    // ~48 MHz
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.sample_valid) begin
            vcount++;
            vtimes.push_back(cyc);
            lq.push_back(bus.audio_l_out);
            rq.push_back(bus.audio_r_out);
            if (prev_v) vwide++;
        end
        if (bus.frame_err) begin
            ecount++;
            if (prev_e) ewide++;
        end
        prev_v = bus.sample_valid;
        prev_e = bus.frame_err;
    end

    task automatic bclk_bit(input logic lrv, input logic dv);
        bus.i2s_bclk = 1'b0;
        bus.i2s_lr   = lrv;
        bus.i2s_d_in = dv;
        #(bh);
        bus.i2s_bclk = 1'b1;
        #(bh);
    endtask

    // Slot 0 is the I2S delay slot; slots 25..31 carry pad bits.
    task automatic half_frame(input logic lrv, input logic [23:0] w,
                              input int nslots, input logic [7:0] pad);
        logic b;
        for (int s = 0; s < nslots; s++) begin
            if (s == 0)       b = pad[0];
            else if (s <= 24) b = w[24-s];
            else              b = pad[32-s];
            bclk_bit(lrv, b);
        end
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r, input logic [7:0] pad);
        half_frame(1'b0, l, 32, pad);
        half_frame(1'b1, r, 32, pad);
    endtask

    task automatic test_reset();
        bus.i2s_bclk = 1'b0; bus.i2s_lr = 1'b0; bus.i2s_d_in = 1'b0;
        rst = 1'b0;
        #50000;
        checks++; if (bus.audio_l_out !== 24'h0) begin errors++; $display("FAIL reset_l: got %h expected 000000", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'h0) begin errors++; $display("FAIL reset_r: got %h expected 000000", bus.audio_r_out); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0 = vcount;
        int e0 = ecount;
        frame(24'hA5A5A5, 24'h5A5A5A, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 0) begin errors++; $display("FAIL basic_swallow: got %0d pulses expected 0", vcount - v0); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL basic_prelock: got %b expected 0", bus.locked); end
        frame(24'hA5A5A5, 24'h5A5A5A, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL basic_valid: got %0d pulses expected 1", vcount - v0); end
        checks++; if (bus.audio_l_out !== 24'hA5A5A5) begin errors++; $display("FAIL basic_l: got %h expected a5a5a5", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'h5A5A5A) begin errors++; $display("FAIL basic_r: got %h expected 5a5a5a", bus.audio_r_out); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL basic_locked: got %b expected 1", bus.locked); end
        checks++; if (ecount - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d expected 0", ecount - e0); end
    endtask

    task automatic test_back_to_back();
        int v0 = vcount;
        int e0 = ecount;
        int b  = vtimes.size();
        int d;
        logic [23:0] n;
        for (int i = 1; i <= 10; i++) begin
            n = 24'(i);
            frame(n, ~n, 8'h00);
        end
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", vcount - v0); end
        checks++; if (ecount - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", ecount - e0); end
        checks++; if (vwide !== 0) begin errors++; $display("FAIL b2b_width: got %0d wide pulses expected 0", vwide); end
        if (vtimes.size() >= b + 10) begin
            for (int i = 0; i < 10; i++) begin
                n = 24'(i + 1);
                checks++; if (lq[b+i] !== n) begin errors++; $display("FAIL b2b_l%0d: got %h expected %h", i, lq[b+i], n); end
                checks++; if (rq[b+i] !== ~n) begin errors++; $display("FAIL b2b_r%0d: got %h expected %h", i, rq[b+i], ~n); end
            end
            for (int i = 1; i < 10; i++) begin
                d = vtimes[b+i] - vtimes[b+i-1];
                checks++; if (d < 998 || d > 1002) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 1000+-2", i, d); end
            end
        end
    endtask

    task automatic test_slot_garbage();
        int v0 = vcount;
        int e0 = ecount;
        frame(24'h123456, 24'hFEDCBA, 8'hFF);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL pad_valid: got %0d expected 1", vcount - v0); end
        checks++; if (bus.audio_l_out !== 24'h123456) begin errors++; $display("FAIL pad_l: got %h expected 123456", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'hFEDCBA) begin errors++; $display("FAIL pad_r: got %h expected fedcba", bus.audio_r_out); end
        checks++; if (ecount - e0 !== 0) begin errors++; $display("FAIL pad_err: got %0d expected 0", ecount - e0); end
    endtask

    task automatic test_short_left();
        int v0 = vcount;
        int e0 = ecount;
        half_frame(1'b0, 24'h777777, 16, 8'h00);
        half_frame(1'b1, 24'h888888, 32, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (ecount - e0 !== 1) begin errors++; $display("FAIL short_err: got %0d expected 1", ecount - e0); end
        checks++; if (ewide !== 0) begin errors++; $display("FAIL short_errwidth: got %0d wide pulses expected 0", ewide); end
        checks++; if (vcount - v0 !== 0) begin errors++; $display("FAIL short_valid: got %0d expected 0", vcount - v0); end
        frame(24'h111111, 24'h222222, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL recover_valid: got %0d expected 1", vcount - v0); end
        checks++; if (bus.audio_l_out !== 24'h111111) begin errors++; $display("FAIL recover_l: got %h expected 111111", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'h222222) begin errors++; $display("FAIL recover_r: got %h expected 222222", bus.audio_r_out); end
        checks++; if (ecount - e0 !== 1) begin errors++; $display("FAIL recover_err: got %0d expected 1", ecount - e0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        half_frame(1'b0, 24'h0F0F0F, 32, 8'h00);
        half_frame(1'b1, 24'hF0F0F0, 12, 8'h00);
        rst = 1'b0;
        #1000;
        checks++; if (bus.audio_l_out !== 24'h0) begin errors++; $display("FAIL midrst_l: got %h expected 000000", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'h0) begin errors++; $display("FAIL midrst_r: got %h expected 000000", bus.audio_r_out); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b expected 0", bus.locked); end
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        v0 = vcount;
        half_frame(1'b1, 24'h0, 20, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 0) begin errors++; $display("FAIL midrst_partial: got %0d expected 0", vcount - v0); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_unlocked: got %b expected 0", bus.locked); end
        frame(24'hABCDEF, 24'h135790, 8'h00);
        repeat (8) @(negedge clk);
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL midrst_valid: got %0d expected 1", vcount - v0); end
        checks++; if (bus.audio_l_out !== 24'hABCDEF) begin errors++; $display("FAIL midrst_l2: got %h expected abcdef", bus.audio_l_out); end
        checks++; if (bus.audio_r_out !== 24'h135790) begin errors++; $display("FAIL midrst_r2: got %h expected 135790", bus.audio_r_out); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL midrst_relock: got %b expected 1", bus.locked); end
    endtask

    task automatic test_phase();
        int v0;
        int e0 = ecount;
        bh = 325521;             // 1.536 MHz
        for (int k = 0; k < 8; k++) begin
            v0 = vcount;
            #(k * 2604);
            frame(24'h3C5A96, 24'hC3A569, 8'h00);
            repeat (8) @(negedge clk);
            checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL phase%0d_valid: got %0d expected 1", k, vcount - v0); end
            checks++; if (bus.audio_l_out !== 24'h3C5A96) begin errors++; $display("FAIL phase%0d_l: got %h expected 3c5a96", k, bus.audio_l_out); end
            checks++; if (bus.audio_r_out !== 24'hC3A569) begin errors++; $display("FAIL phase%0d_r: got %h expected c3a569", k, bus.audio_r_out); end
        end
        checks++; if (ecount - e0 !== 0) begin errors++; $display("FAIL phase_err: got %0d expected 0", ecount - e0); end
        checks++; if (vwide !== 0) begin errors++; $display("FAIL phase_width: got %0d wide pulses expected 0", vwide); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_slot_garbage();
        test_short_left();
        test_reset_mid();
        test_phase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
